// File: rtl/noc_output_allocator.sv
// ============================================================================
// Module      : noc_output_allocator
// Description : Wormhole output-port allocator with round-robin head arbitration,
//               head-to-tail locking, registered flit mux and credit flow control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_output_allocator #(
    parameter int N_IN    = 4,
    parameter int FLIT_W  = 34,
    parameter int CREDITS = 4
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic [N_IN-1:0]           in_valid,
    input  logic [N_IN-1:0]           in_head,
    input  logic [N_IN-1:0]           in_tail,
    input  logic [N_IN*FLIT_W-1:0]    in_data,
    output logic [N_IN-1:0]           in_ready,
    output logic                      out_valid,
    output logic [FLIT_W-1:0]         out_data,
    output logic                      out_head,
    output logic                      out_tail,
    input  logic                      credit_i,
    output logic [$clog2(N_IN)-1:0]   owner_o,
    output logic                      locked_o,
    output logic                      err_o
);

    localparam int c_IW = $clog2(N_IN);
    localparam int c_CW = $clog2(CREDITS + 1);
    localparam logic [c_CW-1:0] c_CREDITS = c_CW'(CREDITS);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t            r_state;
    logic [c_IW-1:0]   r_rr_ptr;
    logic [c_IW-1:0]   r_owner;
    logic [c_CW-1:0]   r_credit_cnt;
    logic              r_out_valid;
    logic [FLIT_W-1:0] r_out_data;
    logic              r_out_head;
    logic              r_out_tail;
    logic              r_err;

    logic [N_IN-1:0]   w_cand;
    logic              w_found;
    logic [c_IW-1:0]   w_grant_idx;
    logic [c_IW-1:0]   w_next_rr;
    logic [c_IW-1:0]   w_sel;
    logic [N_IN-1:0]   w_ready;
    logic              w_has_credit;
    logic              w_tx;

    assign w_cand       = in_valid & in_head;
    assign w_has_credit = (r_credit_cnt != '0);

    // Rotating priority search starting at the round-robin pointer
    always_comb begin
        int v_idx;
        v_idx       = 0;
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int i = 0; i < N_IN; i++) begin
            v_idx = int'(r_rr_ptr) + i;
            if (v_idx >= N_IN) begin
                v_idx = v_idx - N_IN;
            end
            if (!w_found && w_cand[v_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = c_IW'(v_idx);
            end
        end
    end

    assign w_next_rr = (int'(w_grant_idx) == N_IN - 1) ? '0 : w_grant_idx + 1'b1;

    // Ready is forced low while reset is held so no flit can be lost into reset
    always_comb begin
        w_ready = '0;
        if (arst && w_has_credit) begin
            if (r_state == S_IDLE) begin
                if (w_found) begin
                    w_ready[w_grant_idx] = 1'b1;
                end
            end else if (in_valid[r_owner]) begin
                w_ready[r_owner] = 1'b1;
            end
        end
    end

    assign w_sel    = (r_state == S_LOCK) ? r_owner : w_grant_idx;
    assign w_tx     = |(in_valid & w_ready);
    assign in_ready = w_ready;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_credit_cnt <= c_CREDITS;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_head   <= 1'b0;
            r_out_tail   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_out_valid <= w_tx;
            if (w_tx) begin
                r_out_data <= in_data[w_sel*FLIT_W +: FLIT_W];
                r_out_head <= in_head[w_sel];
                r_out_tail <= in_tail[w_sel];
            end

            case ({w_tx, credit_i})
                2'b10: r_credit_cnt <= r_credit_cnt - 1'b1;
                2'b01: begin
                    if (r_credit_cnt == c_CREDITS) begin
                        r_err <= 1'b1;
                    end else begin
                        r_credit_cnt <= r_credit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (|(in_valid & ~in_head)) begin
                        r_err <= 1'b1;
                    end
                    if (w_tx) begin
                        r_owner  <= w_grant_idx;
                        r_rr_ptr <= w_next_rr;
                        if (!in_tail[w_grant_idx]) begin
                            r_state <= S_LOCK;
                        end
                    end
                end
                S_LOCK: begin
                    if (w_tx) begin
                        // A stray head inside a packet is flagged but forwarded as body
                        if (in_head[r_owner]) begin
                            r_err <= 1'b1;
                        end
                        if (in_tail[r_owner]) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_head  = r_out_head;
    assign out_tail  = r_out_tail;
    assign owner_o   = r_owner;
    assign locked_o  = (r_state == S_LOCK);
    assign err_o     = r_err;

endmodule

`default_nettype wire

// File: doc/noc_output_allocator.md
Name: noc_output_allocator

Overview:
- Wormhole output-port allocator for one router output.
- Shares the output link among N_IN input ports with round-robin fairness, locking the grant from head flit to tail flit.
- Muxes the winning flit onto a registered output and enforces credit-based flow control toward the downstream input buffer.
- Sits between the router input buffers and the output link; it is the sequencing/locking layer around the round-robin arbiter.

Parameters:
- N_IN, 4, number of requesting input ports (>=2).
- FLIT_W, 34, flit payload width in bits.
- CREDITS, 4, downstream buffer depth; initial and maximum credit count (>=1).

Ports:
- clk  input  1  clock, rising edge.
- arst  input  1  reset, asynchronous, active-low (asserted when 0).
- in_valid  input  N_IN  per-port flit valid.
- in_head  input  N_IN  per-port head-flit marker.
- in_tail  input  N_IN  per-port tail-flit marker (head&tail = single-flit packet).
- in_data  input  N_IN*FLIT_W  per-port flit payload, port k at [k*FLIT_W +: FLIT_W].
- in_ready  output  N_IN  per-port flit accepted this cycle.
- out_valid  output  1  registered flit valid toward downstream.
- out_data  output  FLIT_W  registered flit payload.
- out_head  output  1  registered head marker.
- out_tail  output  1  registered tail marker.
- credit_i  input  1  one-cycle pulse, downstream freed one buffer slot.
- owner_o  output  clog2(N_IN)  index of the current/last granted port.
- locked_o  output  1  high while a multi-flit packet holds the output.
- err_o  output  1  sticky protocol-error flag.

Behaviour:
- Reset (arst=0, async): state=IDLE, rr_ptr=0, owner_o=0, credit_cnt=CREDITS, out_valid/out_head/out_tail=0, out_data=0, err_o=0, locked_o=0.
- in_ready is combinational from state, credits and inputs. It is 0 for all ports during reset.
- A transfer on port k means in_valid[k] & in_ready[k]. At most one in_ready bit is high per cycle.
- IDLE state:
  - Candidates are ports with in_valid & in_head.
  - When credit_cnt>0, grant the first candidate searching k = rr_ptr, rr_ptr+1, ... modulo N_IN.
  - Set in_ready[k]=1 the same cycle. owner_o<=k; rr_ptr<=(k+1) mod N_IN.
  - If in_tail[k] is also set, stay IDLE. Otherwise go to LOCK.
  - Valid non-head flits in IDLE are never granted and set err_o.
- LOCK state:
  - in_ready[owner]=1 iff in_valid[owner] & credit_cnt>0. Other ports get in_ready=0 regardless of their requests.
  - On owner transfer with in_tail, return to IDLE.
  - On owner transfer with in_head (missing tail), set err_o, treat the flit as body, stay in LOCK.
- locked_o = (state==LOCK).
- Output register: a transfer in cycle t drives out_valid=1 with that port's data/head/tail in cycle t+1. With no transfer, out_valid=0 next cycle and out_data holds its last value. Latency is exactly 1 cycle; there is no output backpressure.
- Credits (width clog2(CREDITS+1)):
  - Decrement on transfer, increment on credit_i. Both in the same cycle leaves the count unchanged.
  - credit_i at credit_cnt==CREDITS with no transfer: count stays at CREDITS, err_o set.
  - At credit_cnt==0 no transfer occurs. A credit_i in that cycle enables transfers from the next cycle.
- rr_ptr advances only on head-flit grants, never on body/tail flits.
- A reset mid-packet aborts the lock. The packet's remaining flits appear as non-head flits in IDLE (err_o after reset), and are the requester's responsibility.
- err_o clears only on reset.

Test Plan:
- Reset, then all 4 ports present single-flit packets (head&tail) continuously; return a credit_i every cycle -> grants in order 0,1,2,3,0; out_valid high every cycle from cycle 2; owner_o follows the same sequence.
- Port 1 sends a 3-flit packet (H,B,T) while port 2 holds a head -> port 2 stalled (in_ready[2]=0) for 3 cycles; locked_o=1 for 2 cycles; port 2 granted on the cycle after T is accepted.
- CREDITS=4, no credit_i, port 0 streams 6 flits -> exactly 4 accepted, in_ready[0]=0 thereafter. One credit_i pulse -> 5th flit accepted the next cycle.
- credit_i pulse concurrent with a transfer at credit_cnt=2 -> credit_cnt stays 2. credit_i at credit_cnt=4 idle -> err_o=1 and credit_cnt stays 4.
- Owner sends a second head before its tail -> err_o=1, locked_o stays 1, and the flit appears on out_data one cycle later.
- Assert arst=0 mid-packet (after H,B on port 3) -> out_valid=0, locked_o=0, credit_cnt=4 immediately. Port 3's T flit then sets err_o and is not granted.
